// File: rtl/pipe_pkg.sv
// pipe_pkg: shared defaults and occupancy type for the pipeline stage register
package pipe_pkg;
  localparam int PIPE_WIDTH = 32;
  localparam int PIPE_CNT_W = 16;
  typedef logic [1:0] occ_t;
  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_FULL = 2'd2;
  function automatic occ_t occ_next(occ_t occ, logic push, logic pop);
    return occ + occ_t'(push) - occ_t'(pop);
  endfunction
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: 2-entry skid FIFO with registered ready, used when PIPE_STAGE_SKID_EN is defined
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic rd_q, rd_d, wr_q, wr_d, rdy_q, rdy_d;
  occ_t occ_q, occ_d;
  logic in_fire, out_fire;
  // ready comes from a flop so there is no out_ready -> in_ready path
  assign in_ready = rst_b & rdy_q & ~stall & ~flush;
  assign out_valid = occ_q != OCC_EMPTY;
  assign out_data = mem_q[rd_q];
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready & ~stall & ~flush;
  always_comb begin
    mem_d = mem_q;
    if (in_fire) mem_d[wr_q] = in_data;
    wr_d = flush ? 1'b0 : wr_q ^ in_fire;
    rd_d = flush ? 1'b0 : rd_q ^ out_fire;
    occ_d = flush ? OCC_EMPTY : occ_next(occ_q, in_fire, out_fire);
    rdy_d = occ_d != OCC_FULL;
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mem_q <= '{default: '0};
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      occ_q <= OCC_EMPTY;
      rdy_q <= 1'b1;
    end else begin
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      occ_q <= occ_d;
      rdy_q <= rdy_d;
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: stallable/flushable pipeline stage with bubble counter; PIPE_STAGE_SKID_EN selects a 2-entry skid buffer
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH,
  parameter int CNT_W = PIPE_CNT_W
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             stall,
  input  logic             flush,
  output logic [CNT_W-1:0] bubble_cnt
);
  logic [CNT_W-1:0] bubble_q, bubble_d;
`ifdef PIPE_STAGE_SKID_EN
  pipe_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk      (clk),
    .rst_b    (rst_b),
    .stall    (stall),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
  );
`else
  logic valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic in_fire, out_fire;
  assign in_ready = rst_b & ~stall & ~flush & (~valid_q | out_ready);
  assign in_fire = in_valid & in_ready;
  assign out_fire = valid_q & out_ready & ~stall & ~flush;
  always_comb begin
    valid_d = flush ? 1'b0 : in_fire ? 1'b1 : out_fire ? 1'b0 : valid_q;
    data_d = in_fire ? in_data : data_q;
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_q <= 1'b0;
      data_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data = data_q;
`endif
  // saturating count of empty, unstalled cycles
  always_comb bubble_d = (~out_valid & ~stall & ~&bubble_q) ? bubble_q + CNT_W'(1) : bubble_q;
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) bubble_q <= '0;
    else bubble_q <= bubble_d;
  end
  assign bubble_cnt = bubble_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg (either PIPE_STAGE_SKID_EN setting)
module tb_pipe_stage_reg;
  logic clk = 1'b0;
  logic rst_b = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready, out_valid;
  logic [7:0] out_data;
  logic [3:0] bubble_cnt;
  int total = 0, bad = 0;
  pipe_stage_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .stall     (stall),
    .flush     (flush),
    .bubble_cnt(bubble_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b0;
    {in_valid, out_ready, stall, flush} = '0;
    in_data = '0;
    @(negedge clk);
    rst_b = 1'b1;
  endtask
  initial begin
    logic [7:0] got [4];
    int idx, n, occ;
    logic seen11, exp_rdy, fi, fo;
    #1 rst_b = 1'b0;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_bubble", bubble_cnt, 0);
    chk("rst_ready", in_ready, 0);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (3) tick();
    chk("idle_bubble3", bubble_cnt, 3);
    chk("idle_ready", in_ready, 1);
    // back-to-back streaming
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data = 8'(i);
      out_ready = 1'b1;
      #1 chk("stream_rdy", in_ready, 1);
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain", out_valid, 0);
    chk("stream_bubble", bubble_cnt, 1);
    // stall holds output
    do_reset();
    in_valid = 1'b1;
    in_data = 8'hA5;
    tick();
    chk("stall_load", out_data, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall = 1'b1;
      in_data = 8'h77;
      out_ready = 1'b1;
      #1 chk("stall_rdy", in_ready, 0);
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 8'hA5);
      chk("stall_bubble", bubble_cnt, 1);
    end
    @(negedge clk);
    stall = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("stall_release", out_valid, 0);
    chk("stall_bubble_end", bubble_cnt, 1);
    // flush wins over stall
    do_reset();
    in_valid = 1'b1;
    in_data = 8'h31;
    tick();
    @(negedge clk);
    in_data = 8'h32;
    tick();
    chk("flush_pre_valid", out_valid, 1);
    chk("flush_pre_data", out_data, 8'h31);
    @(negedge clk);
    flush = 1'b1;
    stall = 1'b1;
    in_data = 8'h33;
    #1 chk("flush_rdy", in_ready, 0);
    tick();
    chk("flush_valid", out_valid, 0);
    @(negedge clk);
    {flush, stall, in_valid} = '0;
    out_ready = 1'b1;
    tick();
    chk("flush_empty", out_valid, 0);
    chk("flush_bubble", bubble_cnt, 2);
    // backpressure: out_ready low for one cycle while 0x11 is at the head
    do_reset();
    idx = 0;
    n = 0;
    occ = 0;
    seen11 = 1'b0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      in_valid = idx < 4;
      in_data = 8'h10 + 8'(idx);
      out_ready = !(occ != 0 && out_data == 8'h11 && !seen11);
      if (!out_ready) seen11 = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
      exp_rdy = occ < 2;
`else
      exp_rdy = occ == 0 || out_ready;
`endif
      #1;
      chk("bp_rdy", in_ready, exp_rdy);
      chk("bp_valid", out_valid, occ != 0);
      fi = in_valid & exp_rdy;
      fo = (occ != 0) & out_ready;
      if (fo) begin
        got[n] = out_data;
        n++;
      end
      if (fi) idx++;
      occ = occ + int'(fi) - int'(fo);
      @(negedge clk);
    end
    chk("bp_count", n, 4);
    for (int i = 0; i < n; i++) chk("bp_order", got[i], 8'h10 + 8'(i));
    // asynchronous reset mid-transfer, then saturation
    do_reset();
    in_valid = 1'b1;
    in_data = 8'h5A;
    tick();
    chk("mid_loaded", out_valid, 1);
    #2 rst_b = 1'b0;
    #1;
    chk("mid_valid", out_valid, 0);
    chk("mid_data", out_data, 0);
    chk("mid_bubble", bubble_cnt, 0);
    chk("mid_rdy", in_ready, 0);
    tick();
    chk("mid_hold", out_valid, 0);
    @(negedge clk);
    rst_b = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("mid_discard", out_valid, 0);
    chk("mid_bubble1", bubble_cnt, 1);
    repeat (13) tick();
    chk("sat_14", bubble_cnt, 14);
    repeat (6) tick();
    chk("sat_15", bubble_cnt, 15);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL expose parameter WIDTH, default 32, payload width in bits (1..256).
REQ-002 SHALL expose parameter CNT_W, default 16, bubble-counter width in bits (1..32).
REQ-003 SHALL expose port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL expose port rst_b, input, 1, asynchronous active-low reset.
REQ-005 SHALL expose port in_valid, input, 1, upstream payload valid.
REQ-006 SHALL expose port in_data, input, WIDTH, upstream payload.
REQ-007 SHALL expose port in_ready, output, 1, stage can accept this cycle.
REQ-008 SHALL expose port out_valid, output, 1, head entry valid.
REQ-009 SHALL expose port out_data, output, WIDTH, head entry payload.
REQ-010 SHALL expose port out_ready, input, 1, downstream accepts.
REQ-011 SHALL expose port stall, input, 1, global freeze (cache miss).
REQ-012 SHALL expose port flush, input, 1, kill all held entries (branch/exception).
REQ-013 SHALL expose port bubble_cnt, output, CNT_W, count of empty non-stalled cycles.

Function
REQ-014 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready & !stall & !flush.
REQ-015 SHALL hold state unchanged while stall=1 and flush=0: no enqueue (in_ready=0), no dequeue, out_valid/out_data held.
REQ-016 SHALL give flush priority over stall and handshakes: next cycle all entries empty, out_valid=0, in_fire suppressed (in_ready=0 during flush).
REQ-017 SHALL preserve FIFO order; no payload duplicated or dropped except on flush.
REQ-018 SHALL have one-cycle latency: payload accepted on edge N appears on out_data after edge N when the stage was empty.
REQ-019 SHALL allow simultaneous in_fire and out_fire on a full single entry (pass-through refill) with no bubble.
REQ-020 SHALL increment bubble_cnt on every cycle with out_valid=0 & stall=0, saturating at 2^CNT_W-1 (no wrap).
REQ-021 SHALL keep out_data stable whenever out_valid=1 and out_fire=0.

Reset
REQ-022 SHALL, on rst_b=0, immediately force out_valid=0, out_data=0, bubble_cnt=0, all entries empty, independent of clk.
REQ-023 SHALL drive in_ready=0 while rst_b=0 and resume normal operation on the first rising edge after deassertion.
REQ-024 SHALL discard any in-flight payload when reset asserts mid-transfer.

Configuration
REQ-025 SHALL recognise macro PIPE_STAGE_SKID_EN.
REQ-026 SHALL, with PIPE_STAGE_SKID_EN defined, use a 2-entry skid buffer: in_ready is a flop output (= !full & !stall & !flush), sustaining one transfer per cycle with out_ready low for one cycle without losing data.
REQ-027 SHALL, without PIPE_STAGE_SKID_EN, use a single entry: in_ready = !stall & !flush & (!out_valid | out_ready) combinationally.
REQ-028 SHALL present identical ordering, flush, stall, reset and bubble_cnt behaviour in both configurations.

Structure
REQ-029 SHALL place default WIDTH/CNT_W constants and the occupancy typedef (2-bit count) in shared package pipe_pkg.
REQ-030 SHALL implement the 2-entry buffer as sub-module pipe_skid_buf, instantiated only when PIPE_STAGE_SKID_EN is defined.

Verification
REQ-031 SHALL cover reset: rst_b=0 mid-transfer with out_valid=1 -> out_valid=0, bubble_cnt=0 without a clock edge.
REQ-032 SHALL cover streaming: in_data 0x1..0x8 back-to-back, out_ready=1 -> 0x1..0x8 out in order, one per cycle, one-cycle latency.
REQ-033 SHALL cover stall: hold 0xA5 at output, stall=1 for 3 cycles with in_valid=1, out_ready=1 -> out_data=0xA5 held, in_ready=0, bubble_cnt unchanged.
REQ-034 SHALL cover flush+stall: flush=1 with stall=1 and 2 entries held -> next cycle out_valid=0, occupancy 0.
REQ-035 SHALL cover backpressure (skid on): stream 0x10..0x13, out_ready=0 for one cycle at 0x11 -> output 0x10,0x11,0x12,0x13, none lost, in_ready drops only after two held.
REQ-036 SHALL cover saturation: CNT_W=4, 20 idle unstalled cycles -> bubble_cnt=15.
